// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, states,
// ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

   localparam logic [5:0] R_TYPE   = 6'h00;
   localparam logic [5:0] J        = 6'h02;
   localparam logic [5:0] JAL      = 6'h03;
   localparam logic [5:0] BEQ      = 6'h04;
   localparam logic [5:0] BNE      = 6'h05;
   localparam logic [5:0] ADDI     = 6'h08;
   localparam logic [5:0] ANDI     = 6'h0C;
   localparam logic [5:0] ORI      = 6'h0D;
   localparam logic [5:0] LUI      = 6'h0F;
   localparam logic [5:0] LW       = 6'h23;
   localparam logic [5:0] SW       = 6'h2B;
   localparam logic [5:0] FUNCT_JR = 6'h08;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_R_EXE    = 4'd7,
      S_R_WB     = 4'd8,
      S_I_EXE    = 4'd9,
      S_I_WB     = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_JAL      = 4'd13,
      S_JR       = 4'd14
   } state_t;

   localparam logic [3:0] ALU_ADD   = 4'b0100;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_LUI   = 4'b0010;
   localparam logic [3:0] ALU_AND   = 4'b0011;
   localparam logic [3:0] ALU_RTYPE = 4'b0111;
   localparam logic [3:0] ALU_LW    = 4'b0101;
   localparam logic [3:0] ALU_SW    = 4'b1001;
   localparam logic [3:0] ALU_BEQ   = 4'b0110;
   localparam logic [3:0] ALU_BNE   = 4'b1000;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_RS     = 2'd3;

   localparam logic [1:0] SRC_B_REG     = 2'd0;
   localparam logic [1:0] SRC_B_FOUR    = 2'd1;
   localparam logic [1:0] SRC_B_IMM     = 2'd2;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

   // States that own the memory bus and therefore run the wait timer.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of one memory access and flags a timeout once the
// count reaches MEM_TIMEOUT with memory still not ready.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic ready,
   output logic timeout
);

   logic [CNT_W-1:0] cnt;

   assign timeout = active && !ready && (cnt == CNT_W'(MEM_TIMEOUT));

   // Outside a memory state, on ready and on timeout the count returns to
   // zero, so every access (including a retried fetch) starts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (active && !ready && !timeout)
         cnt <= cnt + CNT_W'(1);
      else
         cnt <= '0;
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS controller: sequences a shared ALU and unified memory
// through fetch, decode, execute, memory and writeback states.
module multicycle_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       pc_write_eq_o,
   output logic       pc_write_ne_o,
   output logic [1:0] pc_src_o,
   output logic       i_or_d_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       reg_dst_o,
   output logic       jal_o,
   output logic       mem_to_reg_o,
   output logic       reg_write_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [3:0] alu_op_o,
   output logic       instr_done_o,
   output logic       illegal_op_o,
   output logic       bus_error_o,
   output logic [3:0] state_o
);

   state_t state, next_state;
   logic   timeout;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .active  (is_mem_state(state)),
      .ready   (mem_ready_i),
      .timeout (timeout)
   );

   assign state_o = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   next_state = S_FETCH;
         S_FETCH: begin
            if (timeout)          next_state = S_FETCH;
            else if (mem_ready_i) next_state = S_DECODE;
         end
         S_DECODE: begin
            case (opcode_i)
               R_TYPE:                 next_state = (funct_i == FUNCT_JR) ? S_JR : S_R_EXE;
               LW, SW:                 next_state = S_MEM_ADDR;
               ADDI, ANDI, ORI, LUI:   next_state = S_I_EXE;
               BEQ, BNE:               next_state = S_BRANCH;
               J:                      next_state = S_JUMP;
               JAL:                    next_state = S_JAL;
               default:                next_state = S_FETCH;
            endcase
         end
         S_MEM_ADDR: next_state = (opcode_i == SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: begin
            if (timeout)          next_state = S_FETCH;
            else if (mem_ready_i) next_state = S_MEM_WB;
         end
         S_MEM_WR: begin
            if (timeout || mem_ready_i) next_state = S_FETCH;
         end
         S_R_EXE:  next_state = S_R_WB;
         S_I_EXE:  next_state = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR:
            next_state = S_FETCH;
         default:  next_state = S_IDLE;
      endcase
   end

   always_comb begin
      pc_write_o    = 1'b0;
      pc_write_eq_o = 1'b0;
      pc_write_ne_o = 1'b0;
      pc_src_o      = PC_SRC_ALU;
      i_or_d_o      = 1'b0;
      mem_read_o    = 1'b0;
      mem_write_o   = 1'b0;
      ir_write_o    = 1'b0;
      reg_dst_o     = 1'b0;
      jal_o         = 1'b0;
      mem_to_reg_o  = 1'b0;
      reg_write_o   = 1'b0;
      alu_src_a_o   = 1'b0;
      alu_src_b_o   = SRC_B_REG;
      alu_op_o      = 4'b0000;
      instr_done_o  = 1'b0;
      illegal_op_o  = 1'b0;
      bus_error_o   = 1'b0;
      // A timed-out access drops every request and write enable for the cycle.
      if (timeout) begin
         bus_error_o = 1'b1;
      end else begin
         case (state)
            S_FETCH: begin
               mem_read_o  = 1'b1;
               alu_src_b_o = SRC_B_FOUR;
               alu_op_o    = ALU_ADD;
               ir_write_o  = mem_ready_i;
               pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
               alu_src_b_o = SRC_B_IMM_SH2;
               alu_op_o    = ALU_ADD;
               case (opcode_i)
                  R_TYPE, LW, SW, ADDI, ANDI, ORI, LUI, BEQ, BNE, J, JAL:
                     illegal_op_o = 1'b0;
                  default:
                     illegal_op_o = 1'b1;
               endcase
            end
            S_MEM_ADDR: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = SRC_B_IMM;
               alu_op_o    = (opcode_i == SW) ? ALU_SW : ALU_LW;
            end
            S_MEM_RD: begin
               mem_read_o = 1'b1;
               i_or_d_o   = 1'b1;
            end
            S_MEM_WB: begin
               reg_write_o  = 1'b1;
               mem_to_reg_o = 1'b1;
               instr_done_o = 1'b1;
            end
            S_MEM_WR: begin
               mem_write_o  = 1'b1;
               i_or_d_o     = 1'b1;
               instr_done_o = mem_ready_i;
            end
            S_R_EXE: begin
               alu_src_a_o = 1'b1;
               alu_op_o    = ALU_RTYPE;
            end
            S_R_WB: begin
               reg_write_o  = 1'b1;
               reg_dst_o    = 1'b1;
               instr_done_o = 1'b1;
            end
            S_I_EXE: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = SRC_B_IMM;
               case (opcode_i)
                  ORI:     alu_op_o = ALU_OR;
                  LUI:     alu_op_o = ALU_LUI;
                  ANDI:    alu_op_o = ALU_AND;
                  default: alu_op_o = ALU_ADD;
               endcase
            end
            S_I_WB: begin
               reg_write_o  = 1'b1;
               instr_done_o = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a_o   = 1'b1;
               alu_op_o      = (opcode_i == BNE) ? ALU_BNE : ALU_BEQ;
               pc_src_o      = PC_SRC_ALUOUT;
               pc_write_eq_o = (opcode_i == BEQ);
               pc_write_ne_o = (opcode_i == BNE);
               instr_done_o  = 1'b1;
            end
            S_JUMP: begin
               pc_write_o   = 1'b1;
               pc_src_o     = PC_SRC_JUMP;
               instr_done_o = 1'b1;
            end
            S_JAL: begin
               pc_write_o   = 1'b1;
               pc_src_o     = PC_SRC_JUMP;
               reg_write_o  = 1'b1;
               jal_o        = 1'b1;
               alu_op_o     = ALU_ADD;
               instr_done_o = 1'b1;
            end
            S_JR: begin
               pc_write_o   = 1'b1;
               pc_src_o     = PC_SRC_RS;
               instr_done_o = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multi-cycle controller; each driven cycle pushes
// the hand-computed output vector that the monitor compares at negedge.
module tb_multicycle_control_fsm;

   localparam int W = 27;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode_i = 6'h00;
   logic [5:0] funct_i = 6'h00;
   logic       mem_ready_i = 1'b0;
   logic       pc_write_o, pc_write_eq_o, pc_write_ne_o;
   logic [1:0] pc_src_o;
   logic       i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
   logic       reg_dst_o, jal_o, mem_to_reg_o, reg_write_o;
   logic       alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic [3:0] alu_op_o;
   logic       instr_done_o, illegal_op_o, bus_error_o;
   logic [3:0] state_o;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] act;

   multicycle_control_fsm #(
      .MEM_TIMEOUT (4),
      .CNT_W       (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode_i      (opcode_i),
      .funct_i       (funct_i),
      .mem_ready_i   (mem_ready_i),
      .pc_write_o    (pc_write_o),
      .pc_write_eq_o (pc_write_eq_o),
      .pc_write_ne_o (pc_write_ne_o),
      .pc_src_o      (pc_src_o),
      .i_or_d_o      (i_or_d_o),
      .mem_read_o    (mem_read_o),
      .mem_write_o   (mem_write_o),
      .ir_write_o    (ir_write_o),
      .reg_dst_o     (reg_dst_o),
      .jal_o         (jal_o),
      .mem_to_reg_o  (mem_to_reg_o),
      .reg_write_o   (reg_write_o),
      .alu_src_a_o   (alu_src_a_o),
      .alu_src_b_o   (alu_src_b_o),
      .alu_op_o      (alu_op_o),
      .instr_done_o  (instr_done_o),
      .illegal_op_o  (illegal_op_o),
      .bus_error_o   (bus_error_o),
      .state_o       (state_o)
   );

   // Field order: state | pc_write,eq,ne | pc_src | i_or_d,mem_read,mem_write,ir_write
   //              | reg_dst,jal,mem_to_reg,reg_write | src_a | src_b | alu_op | done,illegal,bus_error
   assign act = {state_o, pc_write_o, pc_write_eq_o, pc_write_ne_o, pc_src_o,
                 i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
                 reg_dst_o, jal_o, mem_to_reg_o, reg_write_o,
                 alu_src_a_o, alu_src_b_o, alu_op_o,
                 instr_done_o, illegal_op_o, bus_error_o};

   function automatic logic [W-1:0] ov(input logic [3:0] st, input logic [2:0] pcw,
                                       input logic [1:0] psrc, input logic [3:0] mem,
                                       input logic [3:0] rf, input logic sa,
                                       input logic [1:0] sb, input logic [3:0] aop,
                                       input logic [2:0] fl);
      return {st, pcw, psrc, mem, rf, sa, sb, aop, fl};
   endfunction

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, %0d expected cycles unchecked", exp_q.size());
      $fatal(1, "watchdog expired");
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         n_checks++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL cycle_%0d: got state=%0d vec=%h, expected state=%0d vec=%h",
                     cyc, act[W-1 -: 4], act, e[W-1 -: 4], e);
         end
         cyc++;
      end
   end

   // Driver tasks
   task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input logic [W-1:0] e);
      @(posedge clk);
      #1;
      reset       = rst;
      opcode_i    = op;
      funct_i     = fn;
      mem_ready_i = rdy;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   logic [W-1:0] e_idle, e_fetch_rdy, e_fetch_wait, e_fetch_to, e_decode, e_decode_ill;
   logic [W-1:0] e_r_exe, e_r_wb, e_addr_lw, e_addr_sw, e_mem_rd, e_mem_wb;
   logic [W-1:0] e_mem_wr_wait, e_mem_wr_rdy, e_i_exe_ori, e_i_wb;
   logic [W-1:0] e_bne, e_jump, e_jal, e_jr;

   initial begin
      e_idle        = ov(4'd0,  3'b000, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 3'b000);
      e_fetch_rdy   = ov(4'd1,  3'b100, 2'd0, 4'b0101, 4'b0000, 1'b0, 2'd1, 4'b0100, 3'b000);
      e_fetch_wait  = ov(4'd1,  3'b000, 2'd0, 4'b0100, 4'b0000, 1'b0, 2'd1, 4'b0100, 3'b000);
      e_fetch_to    = ov(4'd1,  3'b000, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 3'b001);
      e_decode      = ov(4'd2,  3'b000, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd3, 4'b0100, 3'b000);
      e_decode_ill  = ov(4'd2,  3'b000, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd3, 4'b0100, 3'b010);
      e_r_exe       = ov(4'd7,  3'b000, 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0111, 3'b000);
      e_r_wb        = ov(4'd8,  3'b000, 2'd0, 4'b0000, 4'b1001, 1'b0, 2'd0, 4'b0000, 3'b100);
      e_addr_lw     = ov(4'd3,  3'b000, 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd2, 4'b0101, 3'b000);
      e_addr_sw     = ov(4'd3,  3'b000, 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd2, 4'b1001, 3'b000);
      e_mem_rd      = ov(4'd4,  3'b000, 2'd0, 4'b1100, 4'b0000, 1'b0, 2'd0, 4'b0000, 3'b000);
      e_mem_wb      = ov(4'd5,  3'b000, 2'd0, 4'b0000, 4'b0011, 1'b0, 2'd0, 4'b0000, 3'b100);
      e_mem_wr_wait = ov(4'd6,  3'b000, 2'd0, 4'b1010, 4'b0000, 1'b0, 2'd0, 4'b0000, 3'b000);
      e_mem_wr_rdy  = ov(4'd6,  3'b000, 2'd0, 4'b1010, 4'b0000, 1'b0, 2'd0, 4'b0000, 3'b100);
      e_i_exe_ori   = ov(4'd9,  3'b000, 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd2, 4'b0001, 3'b000);
      e_i_wb        = ov(4'd10, 3'b000, 2'd0, 4'b0000, 4'b0001, 1'b0, 2'd0, 4'b0000, 3'b100);
      e_bne         = ov(4'd11, 3'b001, 2'd1, 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b1000, 3'b100);
      e_jump        = ov(4'd12, 3'b100, 2'd2, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 3'b100);
      e_jal         = ov(4'd13, 3'b100, 2'd2, 4'b0000, 4'b0101, 1'b0, 2'd0, 4'b0100, 3'b100);
      e_jr          = ov(4'd14, 3'b100, 2'd3, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 3'b100);

      // Reset held three cycles, then one IDLE cycle with reset low
      for (int i = 0; i < 3; i++) step(1'b1, 6'h00, 6'h00, 1'b0, e_idle);
      step(1'b0, 6'h00, 6'h20, 1'b1, e_idle);

      // R-type add
      step(1'b0, 6'h00, 6'h20, 1'b1, e_fetch_rdy);
      step(1'b0, 6'h00, 6'h20, 1'b1, e_decode);
      step(1'b0, 6'h00, 6'h20, 1'b1, e_r_exe);
      step(1'b0, 6'h00, 6'h20, 1'b1, e_r_wb);

      // LW with two wait states in MEM_RD
      step(1'b0, 6'h23, 6'h00, 1'b1, e_fetch_rdy);
      step(1'b0, 6'h23, 6'h00, 1'b1, e_decode);
      step(1'b0, 6'h23, 6'h00, 1'b1, e_addr_lw);
      step(1'b0, 6'h23, 6'h00, 1'b0, e_mem_rd);
      step(1'b0, 6'h23, 6'h00, 1'b0, e_mem_rd);
      step(1'b0, 6'h23, 6'h00, 1'b1, e_mem_rd);
      step(1'b0, 6'h23, 6'h00, 1'b1, e_mem_wb);

      // ORI
      step(1'b0, 6'h0D, 6'h00, 1'b1, e_fetch_rdy);
      step(1'b0, 6'h0D, 6'h00, 1'b0, e_decode);
      step(1'b0, 6'h0D, 6'h00, 1'b1, e_i_exe_ori);
      step(1'b0, 6'h0D, 6'h00, 1'b1, e_i_wb);

      // BNE
      step(1'b0, 6'h05, 6'h00, 1'b1, e_fetch_rdy);
      step(1'b0, 6'h05, 6'h00, 1'b1, e_decode);
      step(1'b0, 6'h05, 6'h00, 1'b1, e_bne);

      // JR
      step(1'b0, 6'h00, 6'h08, 1'b1, e_fetch_rdy);
      step(1'b0, 6'h00, 6'h08, 1'b1, e_decode);
      step(1'b0, 6'h00, 6'h08, 1'b1, e_jr);

      // JAL
      step(1'b0, 6'h03, 6'h00, 1'b1, e_fetch_rdy);
      step(1'b0, 6'h03, 6'h00, 1'b1, e_decode);
      step(1'b0, 6'h03, 6'h00, 1'b1, e_jal);

      // Illegal opcode returns straight to FETCH
      step(1'b0, 6'h3F, 6'h00, 1'b1, e_fetch_rdy);
      step(1'b0, 6'h3F, 6'h00, 1'b1, e_decode_ill);

      // SW with one wait state
      step(1'b0, 6'h2B, 6'h00, 1'b1, e_fetch_rdy);
      step(1'b0, 6'h2B, 6'h00, 1'b1, e_decode);
      step(1'b0, 6'h2B, 6'h00, 1'b1, e_addr_sw);
      step(1'b0, 6'h2B, 6'h00, 1'b0, e_mem_wr_wait);
      step(1'b0, 6'h2B, 6'h00, 1'b1, e_mem_wr_rdy);

      // J
      step(1'b0, 6'h02, 6'h00, 1'b1, e_fetch_rdy);
      step(1'b0, 6'h02, 6'h00, 1'b1, e_decode);
      step(1'b0, 6'h02, 6'h00, 1'b1, e_jump);

      // SW interrupted by reset while waiting in MEM_WR
      step(1'b0, 6'h2B, 6'h00, 1'b1, e_fetch_rdy);
      step(1'b0, 6'h2B, 6'h00, 1'b1, e_decode);
      step(1'b0, 6'h2B, 6'h00, 1'b1, e_addr_sw);
      step(1'b0, 6'h2B, 6'h00, 1'b0, e_mem_wr_wait);
      @(posedge clk);
      #2;
      check("pre_reset_mem_wr", act, e_mem_wr_wait);
      reset = 1'b1;
      #1;
      check("async_reset_outputs", act, e_idle);
      step(1'b1, 6'h00, 6'h00, 1'b0, e_idle);
      step(1'b0, 6'h00, 6'h00, 1'b0, e_idle);

      // Fetch timeout: four waits, bus error on the fifth, then retry succeeds
      for (int i = 0; i < 4; i++) step(1'b0, 6'h02, 6'h00, 1'b0, e_fetch_wait);
      step(1'b0, 6'h02, 6'h00, 1'b0, e_fetch_to);
      step(1'b0, 6'h02, 6'h00, 1'b1, e_fetch_rdy);
      step(1'b0, 6'h02, 6'h00, 1'b1, e_decode);
      step(1'b0, 6'h02, 6'h00, 1'b1, e_jump);

      // Drain the scoreboard with a bounded wait
      @(negedge clk);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle controller for the MIPS core. Replaces the single-cycle opcode decoder with a state machine that sequences one shared ALU and one unified instruction/data memory across FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
- Sits beside the datapath. Takes opcode and funct from the instruction register and a ready handshake from memory. Drives all datapath enables and muxes.

Parameters:
- MEM_TIMEOUT, 15, max wait cycles for mem_ready_i per access before bus_error_o (range 1..255).
- CNT_W, 8, width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode_i  in  6  IR[31:26]; valid from DECODE onward
- funct_i  in  6  IR[5:0]
- mem_ready_i  in  1  memory has completed the current read/write this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_eq_o  out  1  PC load if ALU zero
- pc_write_ne_o  out  1  PC load if ALU not zero
- pc_src_o  out  2  0 ALU result, 1 ALUOut register, 2 jump target, 3 register rs
- i_or_d_o  out  1  memory address: 0 PC, 1 ALUOut
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  IR load
- reg_dst_o  out  1  write register: 0 rt, 1 rd
- jal_o  out  1  write register forced to $31; write data = PC
- mem_to_reg_o  out  1  write data from MDR
- reg_write_o  out  1  register file write enable
- alu_src_a_o  out  1  0 PC, 1 register A
- alu_src_b_o  out  2  0 register B, 1 constant 4, 2 sign-extended immediate, 3 immediate shifted left by 2
- alu_op_o  out  4  ALU control code (see Behaviour)
- instr_done_o  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op_o  out  1  one-cycle pulse in DECODE for an unsupported opcode
- bus_error_o  out  1  one-cycle pulse on memory timeout
- state_o  out  4  current state encoding, for debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXE=7, R_WB=8, I_EXE=9, I_WB=10, BRANCH=11, JUMP=12, JAL=13, JR=14.
- Reset asserted: state=IDLE, wait counter=0, every output 0, state_o=0. IDLE always moves to FETCH on the next edge.
- Outputs are decoded combinationally from state, opcode_i, funct_i and mem_ready_i.
- ALU codes:
  - add = 0100: used in FETCH, DECODE, ADDI and JAL.
  - ORI 0001, LUI 0010, ANDI 0011, R-type 0111, LW 0101, SW 1001, BEQ 0110, BNE 1000.
- FETCH:
  - Drives mem_read=1, i_or_d=0, src_a=0, src_b=1, alu_op=0100, pc_src=0.
  - ir_write and pc_write are asserted only in a cycle where mem_ready_i=1; FETCH then advances to DECODE.
  - Otherwise FETCH holds and the counter increments.
- DECODE: src_a=0, src_b=3, alu_op=0100 (branch target into ALUOut). Next state by opcode:
  - 0x00 with funct 0x08 -> JR; other 0x00 -> R_EXE.
  - 0x23 or 0x2B -> MEM_ADDR.
  - 0x08, 0x0C, 0x0D, 0x0F -> I_EXE.
  - 0x04 or 0x05 -> BRANCH.
  - 0x02 -> JUMP; 0x03 -> JAL.
  - Any other opcode: pulse illegal_op_o and go to FETCH. No register or memory side effects.
- MEM_ADDR: src_a=1, src_b=2, alu_op 0101 (LW) or 1001 (SW). Next state MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, i_or_d=1. Waits on mem_ready_i like FETCH, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done. -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1, held until mem_ready_i. instr_done is asserted in the ready cycle. -> FETCH.
- R_EXE: src_a=1, src_b=0, alu_op=0111 -> R_WB.
- R_WB: reg_write=1, reg_dst=1, instr_done -> FETCH.
- I_EXE: src_a=1, src_b=2, alu_op per opcode -> I_WB.
- I_WB: reg_write=1, reg_dst=0, instr_done -> FETCH.
- BRANCH: src_a=1, src_b=0, alu_op 0110/1000, pc_src=1, pc_write_eq (BEQ) or pc_write_ne (BNE), instr_done -> FETCH.
- JUMP: pc_write=1, pc_src=2, instr_done -> FETCH.
- JAL: pc_write=1, pc_src=2, reg_write=1, jal=1, instr_done -> FETCH.
- JR: pc_write=1, pc_src=3, instr_done -> FETCH.
- Latency with zero wait states:
  - 3 cycles: BRANCH, JUMP, JAL, JR.
  - 4 cycles: R-type, I-type ALU, SW.
  - 5 cycles: LW.
  - Each wait state adds one cycle.
- Wait counter:
  - Cleared on entry to any memory state and on mem_ready_i.
  - When the counter equals MEM_TIMEOUT with mem_ready_i=0: pulse bus_error_o, deassert all requests and go to FETCH.
  - PC, IR and register file are not written in that cycle.
  - A timeout in FETCH retries the fetch at the same PC.
- mem_ready_i outside memory states is ignored.
- Reset asserted in any state, including mid-wait, returns to IDLE immediately. No partial write is issued after reset.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode and funct localparams (R_TYPE, ADDI, ORI, LUI, ANDI, LW, SW, BEQ, BNE, J, JAL, FUNCT_JR);
  - the state encoding;
  - ALU code constants;
  - pc_src and alu_src_b mux selects.
- One sub-module, mem_wait_timer: counter, clear, timeout flag, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset held 3 cycles, release, opcode 0x00 funct 0x20, mem_ready_i=1 -> states 0,1,2,7,8,1. reg_write and reg_dst=1 only in R_WB; instr_done at cycle 4 after IDLE.
- LW (0x23) with mem_ready_i low 2 cycles in MEM_RD -> MEM_RD held 3 cycles, i_or_d=1. Then MEM_WB with mem_to_reg=1; total 7 cycles.
- BNE (0x05) -> BRANCH with pc_write_ne=1, pc_write_eq=0, alu_op=1000, pc_src=1. JR (0x00/0x08) -> pc_src=3, reg_write=0.
- JAL (0x03) -> JAL state with pc_write=1, pc_src=2, reg_write=1, jal=1. Opcode 0x3F -> illegal_op_o pulse in DECODE, next state FETCH, no writes.
- MEM_TIMEOUT=4, mem_ready_i tied low in FETCH -> bus_error_o pulse on 5th FETCH cycle, ir_write never 1, FETCH re-entered.
- reset asserted during MEM_WR wait -> outputs 0 asynchronously, state_o=0, mem_write deasserted before the next edge.
